usb_ebus_master: RTL and testbench

- Initiator side of the 8-bit external-bus register protocol (USB_D / USB_Addr / RDn / WRn / CEn / ALEn) served by the FPGA register interface.
- Converts a simple command/stream interface into address-latch and strobed data cycles, with programmable setup, pulse and hold timing.
- Used as the FPGA-side bus driver for loopback/self-test builds and as the synthesizable bus model for register-block simulation.

---
 rtl/usb_ebus_master.sv | 117 +++++++++++
 tb/tb_usb_ebus_master.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/usb_ebus_master.sv
// usb_ebus_master: initiator for the 8-bit address-latch / strobed-data external register bus
module usb_ebus_master #(
  parameter int ALE_CYCLES   = 2,
  parameter int SETUP_CYCLES = 1,
  parameter int PULSE_CYCLES = 2,
  parameter int HOLD_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       reset_i,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_len,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       done,
  output logic       busy,
  output logic [7:0] USB_Addr,
  output logic [7:0] USB_D_o,
  output logic       USB_D_oe,
  input  logic [7:0] USB_D_i,
  output logic       USB_RDn,
  output logic       USB_WRn,
  output logic       USB_CEn,
  output logic       USB_ALEn
);
  typedef enum logic [2:0] {IDLE, ALE, WDATA, SETUP, PULSE, HOLD, DONE} state_t;
  localparam logic [7:0] ALE_LD   = 8'(ALE_CYCLES - 1);
  localparam logic [7:0] SETUP_LD = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] PULSE_LD = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYCLES - 1);
  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d, addr_q, addr_d, dout_q, dout_d, rdat_q, rdat_d;
  logic [8:0] bcnt_q, bcnt_d;
  logic       write_q, write_d;
  // State, phase counter, byte counter and bus data registers; async reset drops the bus immediately
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      bcnt_q  <= 9'd0;
      write_q <= 1'b0;
      addr_q  <= 8'd0;
      dout_q  <= 8'd0;
      rdat_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      rdat_q  <= rdat_d;
    end
  end
  // Next state: each timed phase loads its length minus one on entry and exits when the counter hits zero
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - 8'd1;
    bcnt_d  = bcnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    rdat_d  = rdat_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        state_d = ALE;
        cnt_d   = ALE_LD;
        write_d = cmd_write;
        addr_d  = cmd_addr;
        bcnt_d  = {1'b0, cmd_len};
      end
      ALE: if (cnt_q == 8'd0) begin
        state_d = write_q ? WDATA : SETUP;
        cnt_d   = SETUP_LD;
      end
      WDATA: if (wr_valid) begin
        state_d = SETUP;
        cnt_d   = SETUP_LD;
        dout_d  = wr_data;
      end
      SETUP: if (cnt_q == 8'd0) begin
        state_d = PULSE;
        cnt_d   = PULSE_LD;
      end
      PULSE: if (cnt_q == 8'd0) begin
        state_d = HOLD;
        cnt_d   = HOLD_LD;
        rdat_d  = write_q ? rdat_q : USB_D_i;
      end
      HOLD: if (cnt_q == 8'd0) begin
        state_d = (bcnt_q == 9'd0) ? DONE : (write_q ? WDATA : SETUP);
        bcnt_d  = (bcnt_q == 9'd0) ? bcnt_q : bcnt_q - 9'd1;
        cnt_d   = SETUP_LD;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign cmd_ready = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign wr_ready  = state_q == WDATA;
  assign done      = state_q == DONE;
  assign rd_valid  = state_q == HOLD && !write_q && cnt_q == HOLD_LD;
  assign rd_data   = rdat_q;
  assign USB_Addr  = addr_q;
  assign USB_D_o   = dout_q;
  assign USB_D_oe  = write_q && (state_q inside {SETUP, PULSE, HOLD});
  assign USB_CEn   = !(state_q inside {ALE, WDATA, SETUP, PULSE, HOLD});
  assign USB_ALEn  = state_q != ALE;
  assign USB_RDn   = !(state_q == PULSE && !write_q);
  assign USB_WRn   = !(state_q == PULSE && write_q);
endmodule

// File: tb/tb_usb_ebus_master.sv
// tb_usb_ebus_master: directed checks of bus timing, bursts, stalls, reset and parameter sweep
module tb_usb_ebus_master;
  logic       clk = 1'b0, reset_i = 1'b1;
  logic       cv0 = 1'b0, cv1 = 1'b0, cmd_write = 1'b0, wr_valid = 1'b0;
  logic [7:0] cmd_addr = 8'd0, cmd_len = 8'd0, wr_data = 8'd0, bus_in;
  logic       r0, wrr0, rv0, dn0, bz0, oe0, rdn0, wrn0, cen0, ale0;
  logic [7:0] rd0, addr0, do0;
  logic       r1, wrr1, rv1, dn1, bz1, oe1, rdn1, wrn1, cen1, ale1;
  logic [7:0] rd1, addr1, do1;
  int n_chk = 0, n_fail = 0;
  logic mon_clr = 1'b0;
  int cyc = 0, fall_cyc = 0, n_rdn = 0, rdn_w = 0, bad_w = 0, bad_gap = 0;
  int n_rv = 0, bad_rv = 0, n_oe = 0, n_done = 0, n_ale = 0, n_wrn = 0, addr_chg = 0;
  logic prev_rdn = 1'b1, prev_wrn = 1'b1, prev_ale = 1'b1, prev_cen = 1'b1;
  logic [7:0] addr_prev = 8'd0;
  logic [21:1] t_ale, t_rdn, t_cen, t_rv;

  always #5 clk = ~clk;

  assign bus_in = 8'(n_rdn * 17);

  usb_ebus_master u0 (
    .clk(clk), .reset_i(reset_i), .cmd_valid(cv0), .cmd_ready(r0), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wrr0), .rd_data(rd0), .rd_valid(rv0), .done(dn0), .busy(bz0),
    .USB_Addr(addr0), .USB_D_o(do0), .USB_D_oe(oe0), .USB_D_i(bus_in),
    .USB_RDn(rdn0), .USB_WRn(wrn0), .USB_CEn(cen0), .USB_ALEn(ale0)
  );

  usb_ebus_master #(.ALE_CYCLES(1), .SETUP_CYCLES(3), .PULSE_CYCLES(1), .HOLD_CYCLES(4)) u1 (
    .clk(clk), .reset_i(reset_i), .cmd_valid(cv1), .cmd_ready(r1), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wrr1), .rd_data(rd1), .rd_valid(rv1), .done(dn1), .busy(bz1),
    .USB_Addr(addr1), .USB_D_o(do1), .USB_D_oe(oe1), .USB_D_i(bus_in),
    .USB_RDn(rdn1), .USB_WRn(wrn1), .USB_CEn(cen1), .USB_ALEn(ale1)
  );

  // Bus observer for u0: strobe widths and spacing, read data order, oe, ALE/done/address activity
  always @(negedge clk) begin
    cyc <= cyc + 1;
    prev_rdn <= rdn0;
    prev_wrn <= wrn0;
    prev_ale <= ale0;
    prev_cen <= cen0;
    addr_prev <= addr0;
    if (mon_clr) begin
      n_rdn <= 0; rdn_w <= 0; bad_w <= 0; bad_gap <= 0; n_rv <= 0; bad_rv <= 0;
      n_oe <= 0; n_done <= 0; n_ale <= 0; n_wrn <= 0; addr_chg <= 0;
    end else begin
      if (!rdn0 && prev_rdn) begin
        n_rdn <= n_rdn + 1;
        if (n_rdn >= 1 && cyc - fall_cyc != 4) bad_gap <= bad_gap + 1;
        fall_cyc <= cyc;
      end
      if (!rdn0) rdn_w <= rdn_w + 1;
      else if (!prev_rdn) begin
        if (rdn_w != 2) bad_w <= bad_w + 1;
        rdn_w <= 0;
      end
      if (rv0) begin
        n_rv <= n_rv + 1;
        if (rd0 !== 8'((n_rv + 1) * 17)) bad_rv <= bad_rv + 1;
      end
      if (oe0) n_oe <= n_oe + 1;
      if (dn0) n_done <= n_done + 1;
      if (!ale0 && prev_ale) n_ale <= n_ale + 1;
      if (!wrn0 && prev_wrn) n_wrn <= n_wrn + 1;
      if (!cen0 && !prev_cen && addr0 !== addr_prev) addr_chg <= addr_chg + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clr();
    mon_clr = 1'b1;
    @(posedge clk);
    @(posedge clk);
    mon_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_done0(input int budget);
    int k = 0;
    while (!dn0 && k < budget) begin
      step();
      k++;
    end
    chk("u0_done_reached", {31'd0, dn0}, 32'd1);
    step();
  endtask

  task automatic start0(input logic w, input logic [7:0] a, input logic [7:0] l);
    cmd_write = w;
    cmd_addr = a;
    cmd_len = l;
    cv0 = 1'b1;
    step();
    cv0 = 1'b0;
  endtask

  initial begin
    step();
    step();
    chk("rst_strobes", {28'd0, rdn0, wrn0, cen0, ale0}, 32'hF);
    chk("rst_outs", {24'd0, oe0, rv0, dn0, wrr0, bz0, r0, 2'd0}, 32'h4);
    chk("rst_data", {8'd0, addr0, do0, rd0}, 32'd0);
    reset_i = 1'b0;
    step();
    // single write, defaults
    wr_data = 8'hA5;
    wr_valid = 1'b1;
    chk("w1_ready_c0", {31'd0, r0}, 32'd1);
    start0(1'b1, 8'h05, 8'd0);
    chk("w1_c1", {20'd0, ale0, cen0, bz0, r0, addr0}, {20'd0, 4'b0010, 8'h05});
    step();
    chk("w1_c2_ale", {31'd0, ale0}, 32'd0);
    step();
    chk("w1_c3", {28'd0, ale0, wrr0, oe0, cen0}, 32'b1100);
    step();
    chk("w1_c4", {22'd0, oe0, wrn0, do0}, {22'd0, 2'b11, 8'hA5});
    step();
    chk("w1_c5_wrn", {31'd0, wrn0}, 32'd0);
    step();
    chk("w1_c6_wrn", {30'd0, wrn0, oe0}, 32'b01);
    step();
    chk("w1_c7_hold", {29'd0, wrn0, oe0, cen0}, 32'b110);
    step();
    chk("w1_c8_done", {29'd0, dn0, cen0, oe0}, 32'b110);
    step();
    wr_valid = 1'b0;
    chk("w1_c9_idle", {30'd0, r0, dn0}, 32'b10);
    // read burst of four
    clr();
    start0(1'b0, 8'h20, 8'd3);
    wait_done0(100);
    chk("rb_rdn_pulses", n_rdn, 4);
    chk("rb_rdn_width_bad", bad_w, 0);
    chk("rb_rdn_gap_bad", bad_gap, 0);
    chk("rb_rv_count", n_rv, 4);
    chk("rb_rv_data_bad", bad_rv, 0);
    chk("rb_last_byte", {24'd0, rd0}, 32'h44);
    chk("rb_oe_cycles", n_oe, 0);
    chk("rb_done_count", n_done, 1);
    // write stall in WDATA
    clr();
    wr_data = 8'h00;
    start0(1'b1, 8'h33, 8'd0);
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      chk("stall_bus", {18'd0, cen0, wrn0, rdn0, ale0, oe0, wrr0, addr0}, {18'd0, 6'b011101, 8'h33});
      step();
    end
    wr_data = 8'h3C;
    wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
    chk("stall_send", {23'd0, oe0, do0}, {23'd0, 1'b1, 8'h3C});
    wait_done0(50);
    chk("stall_wr_pulses", n_wrn, 1);
    // max-length read
    clr();
    start0(1'b0, 8'h7E, 8'd255);
    wait_done0(1200);
    chk("max_rv_count", n_rv, 256);
    chk("max_rv_data_bad", bad_rv, 0);
    chk("max_rdn_pulses", n_rdn, 256);
    chk("max_rdn_width_bad", bad_w, 0);
    chk("max_ale_count", n_ale, 1);
    chk("max_addr_changes", addr_chg, 0);
    chk("max_done_count", n_done, 1);
    chk("max_oe_cycles", n_oe, 0);
    // reset during write pulse
    wr_data = 8'h5A;
    wr_valid = 1'b1;
    start0(1'b1, 8'h44, 8'd0);
    repeat (4) step();
    chk("rp_in_pulse", {31'd0, wrn0}, 32'd0);
    #2 reset_i = 1'b1;
    #1 chk("rp_async", {28'd0, wrn0, cen0, oe0, bz0}, 32'b1100);
    step();
    reset_i = 1'b0;
    wr_valid = 1'b0;
    chk("rp_ready", {31'd0, r0}, 32'd1);
    clr();
    start0(1'b0, 8'h10, 8'd0);
    wait_done0(50);
    chk("rp_read_count", n_rv, 1);
    chk("rp_read_data", {24'd0, rd0}, 32'h11);
    // parameter sweep on u1, two back-to-back reads
    cmd_write = 1'b0;
    cmd_addr = 8'h55;
    cmd_len = 8'd1;
    cv1 = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      step();
      t_ale[c] = ale1;
      t_rdn[c] = rdn1;
      t_cen[c] = cen1;
      t_rv[c] = rv1;
    end
    cv1 = 1'b0;
    chk("sw_ale_trace", {11'd0, t_ale}, {11'd0, 21'b101111111111111111110});
    chk("sw_rdn_trace", {11'd0, t_rdn}, {11'd0, 21'b111111110111111101111});
    chk("sw_cen_trace", {11'd0, t_cen}, {11'd0, 21'b001100000000000000000});
    chk("sw_rv_trace", {11'd0, t_rv}, {11'd0, 21'b000000010000000100000});
    for (int k = 0; k < 40 && !dn1; k++) step();
    chk("sw_second_done", {31'd0, dn1}, 32'd1);
    step();
    chk("sw_idle", {30'd0, r1, cen1}, 32'b11);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
